// File: rtl/cpu_pkg.sv
// Shared CPU constants and fetch FSM state encoding.
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned PC_INC           = 4;
  localparam int unsigned PC_READ_OFS      = 8;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus bundle: imem req/ack, IR valid/ready to decode, branch redirect from execute.
interface ifu_if #(parameter int ADDR_W = 32);

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;
  logic [31:0]       ir;
  logic              ir_valid;
  logic              ir_ready;
  logic [ADDR_W-1:0] ir_pc;
  logic [ADDR_W-1:0] pc_rd;
  logic              br_taken;
  logic [23:0]       br_imm24;

  modport master (
    output imem_req, imem_addr, ir, ir_valid, ir_pc, pc_rd,
    input  imem_ack, imem_rdata, ir_ready, br_taken, br_imm24
  );

  modport slave (
    input  imem_req, imem_addr, ir, ir_valid, ir_pc, pc_rd,
    output imem_ack, imem_rdata, ir_ready, br_taken, br_imm24
  );

endinterface

// File: rtl/ifu_branch_target.sv
// B/BL target: ir_pc + 8 + sign-extended imm24 word offset, wrapping modulo 2^ADDR_W.
module ifu_branch_target
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] ir_pc,
  input  logic [23:0]       br_imm24,
  output logic [ADDR_W-1:0] target
);

  logic [ADDR_W-1:0] ofs;

  assign ofs    = {{(ADDR_W-26){br_imm24[23]}}, br_imm24, 2'b00};
  assign target = ir_pc + ADDR_W'(PC_READ_OFS) + ofs;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, imem req/ack, IR to decode, branch redirect.
// Define IFETCH_PREFETCH_EN for a one-entry prefetch buffer (1 instr/cycle throughput).
//
// state | meaning
// FETCH | imem_req high for fetch_pc, waiting for imem_ack
// HOLD  | ir live, waiting for decode handshake (prefetch build: filling pbuf)
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic  clk,
  input  logic  rst,
  ifu_if.master bus
);

  localparam logic [0:0] ST_FETCH = FETCH;
  localparam logic [0:0] ST_HOLD  = HOLD;

  logic [0:0]        state;
  logic              armed;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] target;
  logic [31:0]       ir_q;
  logic              ir_valid_q;
  logic [ADDR_W-1:0] ir_pc_q;
  logic              req;
  logic              ack;
  logic              hs;

  ifu_branch_target #(.ADDR_W(ADDR_W)) u_branch_target (
    .ir_pc    (ir_pc_q),
    .br_imm24 (bus.br_imm24),
    .target   (target)
  );

  // armed holds the request low for the first cycle after reset, so a reset
  // mid-fetch drops imem_req immediately and stale acks find no request.
  assign ack = bus.imem_ack & req;
  assign hs  = ir_valid_q & bus.ir_ready;

  assign bus.imem_req  = req;
  assign bus.imem_addr = {fetch_pc[ADDR_W-1:2], 2'b00};
  assign bus.ir        = ir_q;
  assign bus.ir_valid  = ir_valid_q;
  assign bus.ir_pc     = ir_pc_q;
  assign bus.pc_rd     = ir_pc_q + ADDR_W'(PC_READ_OFS);

`ifdef IFETCH_PREFETCH_EN

  logic [31:0]       pbuf;
  logic [ADDR_W-1:0] pbuf_pc;
  logic              pbuf_valid;
  logic              drop;
  logic [ADDR_W-1:0] redirect_pc;

  assign req = armed & ((state == ST_FETCH) | ((state == ST_HOLD) & ~pbuf_valid));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_FETCH;
      armed       <= 1'b0;
      fetch_pc    <= RESET_PC;
      ir_q        <= 32'h0;
      ir_valid_q  <= 1'b0;
      ir_pc_q     <= RESET_PC;
      pbuf        <= 32'h0;
      pbuf_pc     <= RESET_PC;
      pbuf_valid  <= 1'b0;
      drop        <= 1'b0;
      redirect_pc <= RESET_PC;
    end else begin
      armed <= 1'b1;
      case (state)
        ST_FETCH: begin
          if (ack && drop) begin
            drop     <= 1'b0;
            fetch_pc <= redirect_pc;
          end else if (ack) begin
            ir_q       <= bus.imem_rdata;
            ir_pc_q    <= fetch_pc;
            ir_valid_q <= 1'b1;
            fetch_pc   <= fetch_pc + ADDR_W'(PC_INC);
            state      <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (hs && bus.br_taken) begin
            pbuf_valid <= 1'b0;
            ir_valid_q <= 1'b0;
            state      <= ST_FETCH;
            // The in-flight address must stay on imem_addr until its ack, so park the target.
            if (req && !ack) begin
              drop        <= 1'b1;
              redirect_pc <= target;
            end else begin
              fetch_pc <= target;
            end
          end else if (hs) begin
            if (pbuf_valid) begin
              ir_q       <= pbuf;
              ir_pc_q    <= pbuf_pc;
              pbuf_valid <= 1'b0;
            end else if (ack) begin
              ir_q     <= bus.imem_rdata;
              ir_pc_q  <= fetch_pc;
              fetch_pc <= fetch_pc + ADDR_W'(PC_INC);
            end else begin
              ir_valid_q <= 1'b0;
              state      <= ST_FETCH;
            end
          end else if (ack) begin
            pbuf       <= bus.imem_rdata;
            pbuf_pc    <= fetch_pc;
            pbuf_valid <= 1'b1;
            fetch_pc   <= fetch_pc + ADDR_W'(PC_INC);
          end
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

`else

  assign req = armed & (state == ST_FETCH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_FETCH;
      armed      <= 1'b0;
      fetch_pc   <= RESET_PC;
      ir_q       <= 32'h0;
      ir_valid_q <= 1'b0;
      ir_pc_q    <= RESET_PC;
    end else begin
      armed <= 1'b1;
      case (state)
        ST_FETCH: begin
          if (ack) begin
            ir_q       <= bus.imem_rdata;
            ir_pc_q    <= fetch_pc;
            ir_valid_q <= 1'b1;
            fetch_pc   <= fetch_pc + ADDR_W'(PC_INC);
            state      <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (hs) begin
            ir_valid_q <= 1'b0;
            state      <= ST_FETCH;
            if (bus.br_taken) fetch_pc <= target;
          end
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

`endif

endmodule
